pixel_denormalizer: RTL and testbench

//  Inverse of the Normalization stage: expands 8-bit unsigned pixels into signed
//  OUT_W-bit fixed-point samples for re-entry into the filter/convolution datapath.
//  out = ((pix - OFFSET) * scale) >>> SHIFT. Streaming, valid/ready, 3-stage pipeline.

---
 rtl/pixel_denormalizer.sv | 113 +++++++++++
 tb/tb_pixel_denormalizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_denormalizer.sv
// pixel_denormalizer: 8-bit unsigned pixel -> signed OUT_W sample, out = ((pix - OFFSET) * scale) >>> SHIFT.
// 3-stage valid/ready pipeline; define DENORM_SAT_EN for clamping at S3 plus sat_cnt.
module pixel_denormalizer #(
    parameter int PIX_W   = 8,
    parameter int OUT_W   = 16,
    parameter int SCALE_W = 12,
    parameter int SHIFT   = 2,
    parameter int OFFSET  = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    input  logic               in_last,
    input  logic               cfg_we,
    input  logic [SCALE_W-1:0] cfg_scale,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic [15:0]        sat_cnt
);
    localparam int STAGES = 3;
    localparam int DIFF_W = PIX_W + 1;
    localparam int PROD_W = DIFF_W + SCALE_W;
`ifdef DENORM_SAT_EN
    localparam int FIT_W  = PROD_W;
`else
    localparam int FIT_W  = OUT_W;
`endif

    typedef struct packed {
        logic [DIFF_W-1:0]  diff;
        logic [SCALE_W-1:0] scale;
        logic               last;
    } s1_t;

    typedef struct packed {
        logic [FIT_W-1:0] val;
        logic             last;
    } s2_t;

    logic                     adv;
    logic [STAGES:1]          vld_pipe;
    logic [SCALE_W-1:0]       scale_q;
    s1_t                      s1_d, s1_q;
    s2_t                      s2_d, s2_q;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         fit;

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv       = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    assign s1_d.diff  = {1'b0, in_pix} - DIFF_W'(OFFSET);
    assign s1_d.scale = scale_q;
    assign s1_d.last  = in_last;

    assign prod       = PROD_W'($signed(s1_q.diff)) * PROD_W'($signed(s1_q.scale));
    assign s2_d.val   = FIT_W'(prod >>> SHIFT);
    assign s2_d.last  = s1_q.last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scale_q <= SCALE_W'(1 << SHIFT);
        else if (cfg_we)
            scale_q <= cfg_scale;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_data <= fit;
            out_last <= s2_q.last;
        end
    end

`ifdef DENORM_SAT_EN
    localparam logic signed [PROD_W-1:0] MAXV = PROD_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] MINV = ~MAXV;

    logic signed [PROD_W-1:0] v;
    logic                     hi, lo;

    assign v   = $signed(s2_q.val);
    assign hi  = v > MAXV;
    assign lo  = v < MINV;
    assign fit = hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                 lo ? {1'b1, {(OUT_W-1){1'b0}}} : v[OUT_W-1:0];

    // Counts only clamped samples that actually enter S3; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_cnt <= '0;
        else if (adv && vld_pipe[2] && (hi || lo) && !(&sat_cnt))
            sat_cnt <= sat_cnt + 16'd1;
    end
`else
    assign fit     = s2_q.val;
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_denormalizer.sv
// Self-checking bench for pixel_denormalizer: directed vectors plus randomized
// valid/ready/cfg traffic checked against an arithmetic scoreboard model.
module tb_pixel_denormalizer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pix = '0;
    logic        in_last = 1'b0;
    logic        cfg_we = 1'b0;
    logic [11:0] cfg_scale = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] sat_cnt;

`ifdef DENORM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pixel_denormalizer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_last(in_last),
        .cfg_we(cfg_we), .cfg_scale(cfg_scale),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sat_cnt(sat_cnt)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, floor division by 4, then clamp or 16-bit wrap.
    function automatic int denorm(input int pix, input int sc, output bit clamped);
        longint v;
        v = longint'(pix - 128) * sc;
        v = (v - (((v % 4) + 4) % 4)) / 4;
        clamped = 1'b0;
        if (SAT) begin
            if (v > 32767) begin v = 32767; clamped = 1'b1; end
            else if (v < -32768) begin v = -32768; clamped = 1'b1; end
        end else begin
            v = ((v % 65536) + 65536) % 65536;
            if (v >= 32768) v -= 65536;
        end
        return int'(v);
    endfunction

    typedef struct {
        int data;
        bit last;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          mscale = 4;
    int          msat = 0;
    int          cyc = 0;
    int          last_out = 0;
    bit          lat_chk = 1'b0;
    bit          stall_prev = 1'b0;
    logic [16:0] prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit   c;
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold", {out_valid, out_last, out_data}, {1'b1, prev});
            if (in_valid && in_ready) begin
                e.data = denorm(int'(in_pix), mscale, c);
                e.last = in_last;
                e.cyc  = cyc;
                sb.push_back(e);
                if (c && msat < 65535) msat++;
            end
            if (cfg_we) mscale = int'($signed(cfg_scale));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data", $signed(out_data), e.data);
                    chk("last", out_last, e.last);
                    if (lat_chk) chk("latency", cyc - e.cyc, 3);
                end
                last_out = int'($signed(out_data));
            end
            stall_prev = out_valid && !out_ready;
            prev = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pix, input bit last);
        bit ok;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pix   = pix[7:0];
        in_last  = last;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", sat_cnt, 0);
        chk("rst_ready", in_ready, 1);

        // unity scale, 3-cycle latency, then back-to-back extremes
        lat_chk = 1'b1;
        send(234, 1'b1);
        drain();
        chk("t1_val", last_out, 106);
        send(0, 1'b0);
        send(255, 1'b1);
        drain();
        chk("t2_val", last_out, 127);
        lat_chk = 1'b0;

        // scale write coinciding with an accept: that pixel keeps the old scale
        cfg_we = 1'b1;
        cfg_scale = 12'd8;
        send(200, 1'b0);
        cfg_we = 1'b0;
        send(200, 1'b1);
        drain();
        chk("t5_val", last_out, 144);

        cfg_we = 1'b1;
        cfg_scale = 12'd2047;
        tick();
        cfg_we = 1'b0;
        send(255, 1'b0);
        drain();
        chk("t3_val", last_out, SAT ? 32767 : -544);
        chk("t3_sat", sat_cnt, SAT ? 1 : 0);

        // reset with three samples in flight
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        chk("t6_inflight", out_valid, 1);
        reset = 1'b1;
        sb.delete();
        mscale = 4;
        msat = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_sat", sat_cnt, 0);
        tick();
        reset = 1'b0;
        send(234, 1'b0);
        drain();
        chk("t6_scale", last_out, 106);

        // downstream stall mid-stream
        fork
            begin
                for (int i = 1; i <= 10; i++) send(i, i == 10);
            end
            begin
                repeat (5) tick();
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_stall_rdy", in_ready, 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_pix    = 8'($urandom);
            in_last   = 1'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            cfg_we    = $urandom_range(0, 15) == 0;
            cfg_scale = 12'($urandom);
            tick();
        end
        cfg_we = 1'b0;
        drain();
        chk("rand_sat", sat_cnt, msat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
